// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage of the pipelined ARM core. Owns the
//             program counter, drives the combinational instruction memory
//             address and captures the returned word into the IF/ID register.
//             Honours stall requests from hazard logic and redirect requests
//             from later stages (redirect has priority over stall).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IMEM_SIZE   instruction memory size in bytes (power of two, > 4)
//    RESET_PC    word-aligned PC loaded while reset is asserted
//  Ports
//    clk          in   1   clock, rising-edge active
//    reset        in   1   asynchronous active-high reset
//    stall        in   1   hold PC and IF/ID this cycle
//    br_taken     in   1   redirect request
//    br_target    in  64   redirect byte address (used as-is, no masking)
//    imem_addr    out 64   instruction memory address (= current PC)
//    imem_instr   in  32   word returned combinationally for imem_addr
//    if_id_pc     out 64   PC of the captured instruction
//    if_id_instr  out 32   captured instruction word
//    if_id_valid  out  1   captured word is a real instruction
//    fault        out  1   sticky fetch fault
//  Build option
//    FETCH_FAULT_CHECK_EN  when defined, each fetch is checked for alignment
//                          and range; a violation halts fetch and sets the
//                          sticky fault flag. Otherwise fault is tied to 0.
// ============================================================================
module fetch_stage #(
   parameter int unsigned IMEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC  = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [63:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        fault
);

   // Elaboration-time sanity check of the memory size.
   generate
      if ((IMEM_SIZE <= 4) || ((IMEM_SIZE & (IMEM_SIZE - 1)) != 0)) begin : g_bad_imem_size
         $error("fetch_stage: IMEM_SIZE must be a power of two greater than 4");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [63:0] pc_q,          pc_d;
   logic [63:0] if_id_pc_q,    if_id_pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        fault_q;
   logic        fetch_bad;     // current PC is an illegal fetch address

   logic [63:0] pc_plus4;
   assign pc_plus4 = pc_q + 64'd4;   // modulo 2^64, carry discarded

`ifdef FETCH_FAULT_CHECK_EN
   // pc + 3 < IMEM_SIZE is evaluated as pc < IMEM_SIZE - 3 so that a PC near
   // 2^64 cannot wrap the sum into range and slip past the check.
   localparam logic [63:0] c_imem_limit = 64'(IMEM_SIZE) - 64'd3;

   logic fault_d;

   assign fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q >= c_imem_limit);

   // Fault is raised only by a fetch that would actually proceed this edge.
   always_comb begin
      fault_d = fault_q | (~br_taken & ~stall & fetch_bad);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`else
   assign fetch_bad = 1'b0;
   assign fault_q   = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic: fault halt > redirect > stall > normal fetch
   // -------------------------------------------------------------------------
   always_comb begin
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;

      if (fault_q) begin
         // Fetch is halted; only reset recovers. Redirects are ignored.
         if_id_valid_d = 1'b0;
      end else if (br_taken) begin
         // Squash the word fetched this cycle; IF/ID payload simply holds.
         pc_d          = br_target;
         if_id_valid_d = 1'b0;
      end else if (!stall) begin
         if (fetch_bad) begin
            // Faulting fetch: PC holds, bubble enters decode.
            if_id_valid_d = 1'b0;
         end else begin
            pc_d          = pc_plus4;
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_instr;
            if_id_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 64'd0;
         if_id_instr_q <= 32'd0;
         if_id_valid_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: all taken straight from flops
   // -------------------------------------------------------------------------
   assign imem_addr   = pc_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_valid = if_id_valid_q;
   assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage. A combinational
//             instruction memory model returns a word derived from the
//             address, so every expected instruction is known in advance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   localparam int unsigned IMEM_SIZE = 1024;
   localparam logic [63:0] RESET_PC  = 64'h0;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        br_taken;
   logic [63:0] br_target;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        fault;

   int n_checks = 0;
   int n_errors = 0;

   fetch_stage #(
      .IMEM_SIZE (IMEM_SIZE),
      .RESET_PC  (RESET_PC)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .fault       (fault)
   );

   // Memory model: word at address A is {8'hE5, A[23:0]}.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {8'hE5, a[23:0]};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the bench must never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; return 1 time unit later for sampling/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [63:0] pc, input logic vld);
      check_eq({tag, ".pc"},    if_id_pc,    pc);
      check_eq({tag, ".instr"}, if_id_instr, {32'd0, mem_word(pc)});
      check_eq({tag, ".valid"}, if_id_valid, vld);
   endtask

   initial begin
      reset     = 1'b1;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 64'd0;

      // Reset state
      step();
      check_eq("rst.imem_addr", imem_addr,   RESET_PC);
      check_eq("rst.pc",        if_id_pc,    64'd0);
      check_eq("rst.instr",     if_id_instr, 64'd0);
      check_eq("rst.valid",     if_id_valid, 64'd0);
      check_eq("rst.fault",     fault,       64'd0);
      reset = 1'b0;

      // Sequential fetch
      step(); check_ifid("e1", 64'd0, 1'b1); check_eq("e1.addr", imem_addr, 64'd4);
      step(); check_ifid("e2", 64'd4, 1'b1); check_eq("e2.addr", imem_addr, 64'd8);

      // Stall three cycles at pc=8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall.addr", imem_addr, 64'd8);
         check_ifid("stall", 64'd4, 1'b1);
      end
      stall = 1'b0;
      step(); check_ifid("rel", 64'd8, 1'b1);  check_eq("rel.addr", imem_addr, 64'd12);
      step(); check_ifid("e4", 64'd12, 1'b1);  check_eq("e4.addr", imem_addr, 64'd16);

      // Redirect wins over stall
      br_taken = 1'b1; br_target = 64'h40; stall = 1'b1;
      step();
      check_eq("br.valid", if_id_valid, 64'd0);
      check_eq("br.addr",  imem_addr,   64'h40);
      br_taken = 1'b0; stall = 1'b0;
      step(); check_ifid("brt", 64'h40, 1'b1); check_eq("brt.addr", imem_addr, 64'h44);

      // Asynchronous reset mid-cycle at pc=0x20
      br_taken = 1'b1; br_target = 64'h20;
      step();
      br_taken = 1'b0;
      check_eq("pre_rst.addr", imem_addr, 64'h20);
      #2 reset = 1'b1;
      #1;
      check_eq("arst.addr",  imem_addr,   RESET_PC);
      check_eq("arst.pc",    if_id_pc,    64'd0);
      check_eq("arst.instr", if_id_instr, 64'd0);
      check_eq("arst.valid", if_id_valid, 64'd0);
      step();
      reset = 1'b0;
      step(); check_ifid("post_rst", RESET_PC, 1'b1);

`ifndef FETCH_FAULT_CHECK_EN
      // PC wrap modulo 2^64
      br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      br_taken = 1'b0;
      step(); check_ifid("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      check_eq("wrap.addr", imem_addr, 64'd0);
`endif

      // Misaligned fetch at 0x3FE
      br_taken = 1'b1; br_target = 64'h3FE;
      step();
      br_taken = 1'b0;
      check_eq("mis.br_valid", if_id_valid, 64'd0);
      step();
`ifdef FETCH_FAULT_CHECK_EN
      check_eq("mis.fault", fault,       64'd1);
      check_eq("mis.valid", if_id_valid, 64'd0);
      check_eq("mis.addr",  imem_addr,   64'h3FE);
      // Redirects are ignored while faulted
      br_taken = 1'b1; br_target = 64'h400;
      step();
      check_eq("flt1.addr", imem_addr, 64'h3FE);
      br_target = 64'h0;
      step();
      br_taken = 1'b0;
      check_eq("flt2.fault", fault,       64'd1);
      check_eq("flt2.valid", if_id_valid, 64'd0);
      check_eq("flt2.addr",  imem_addr,   64'h3FE);
      step();
      check_eq("flt3.fault", fault, 64'd1);
      // Only reset clears the fault
      reset = 1'b1;
      #1 check_eq("clr.fault", fault, 64'd0);
      step();
      reset = 1'b0;
      // Last legal word 0x3FC, then 0x400 is out of range
      br_taken = 1'b1; br_target = 64'h3FC;
      step();
      br_taken = 1'b0;
      step(); check_ifid("last", 64'h3FC, 1'b1);
      check_eq("last.fault", fault, 64'd0);
      check_eq("last.addr",  imem_addr, 64'h400);
      step();
      check_eq("oor.fault", fault,       64'd1);
      check_eq("oor.valid", if_id_valid, 64'd0);
      check_eq("oor.addr",  imem_addr,   64'h400);
`else
      check_ifid("mis", 64'h3FE, 1'b1);
      check_eq("mis.fault", fault,     64'd0);
      check_eq("mis.addr",  imem_addr, 64'h402);
      br_taken = 1'b1; br_target = 64'h400;
      step();
      br_taken = 1'b0;
      step(); check_ifid("oor", 64'h400, 1'b1);
      check_eq("oor.fault", fault, 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined ARM core: owns the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It accepts stall requests from hazard logic and redirect (taken-branch) requests from later stages. It sits directly upstream of `instructmem` and feeds the decode stage.

## Interface
- `IMEM_SIZE`, 1024: instruction memory size in bytes; power of two, greater than 4.
- `RESET_PC`, 64'h0: PC value loaded on reset; word-aligned.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID contents this cycle.
- `br_taken`  in  1  redirect request from a later stage.
- `br_target`  in  64  byte address to redirect to when `br_taken`=1.
- `imem_addr`  out  64  address to instruction memory; always equals the current PC.
- `imem_instr`  in  32  instruction word returned combinationally for `imem_addr`.
- `if_id_pc`  out  64  PC of the captured instruction.
- `if_id_instr`  out  32  captured instruction word.
- `if_id_valid`  out  1  captured word is a real instruction, not a bubble.
- `fault`  out  1  sticky fetch fault; see Configuration.

## Operation
- State: `pc` (64b), IF/ID register {`if_id_pc`, `if_id_instr`, `if_id_valid`}, `fault` flag.
- Reset values while `reset`=1, applied asynchronously: `pc`=RESET_PC, `if_id_pc`=0, `if_id_instr`=0, `if_id_valid`=0, `fault`=0.
- `imem_addr` = `pc`, combinational, no added logic.
- Per rising edge, priority order:
  - `br_taken`=1: `pc` <= `br_target`; `if_id_valid` <= 0, which squashes the word fetched this cycle. `if_id_pc`/`if_id_instr` may update or hold; decode ignores them when invalid. Redirect wins over `stall`.
  - else `stall`=1: `pc` and the whole IF/ID register hold.
  - else: `pc` <= `pc` + 4; `if_id_pc` <= `pc`; `if_id_instr` <= `imem_instr`; `if_id_valid` <= 1.
- Arithmetic: `pc` + 4 is 64-bit modulo 2^64. Wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal in the datapath. Carry is discarded.
- `br_target` is not modified by this block: no alignment masking.
- Reset asserted mid-stall or mid-redirect: reset wins; the next fetch after deassertion is at RESET_PC.

## Timing
- Fetch latency: 1 cycle. A word at address A, presented in cycle N, is visible on `if_id_*` after edge N.
- Redirect penalty: 1 bubble. With `br_taken` sampled at edge N:
  - after edge N, `if_id_valid`=0 and `pc`=`br_target`;
  - after edge N+1, the instruction at the target is in IF/ID with `if_id_valid`=1 (absent stall).
- Stall: each stalled edge repeats state exactly. No instruction is lost or duplicated across stall release.
- No combinational path from any input to `if_id_*` or `fault`. `imem_addr` depends only on state.

## Configuration
- `FETCH_FAULT_CHECK_EN` defined:
  - Each non-stalled, non-redirected fetch checks `pc`[1:0]==0 and `pc`+3 < IMEM_SIZE.
  - On a violation, `fault` <= 1. `fault` is sticky and cleared only by `reset`.
  - The faulting fetch loads `if_id_valid` <= 0 and `pc` holds, so fetch halts.
  - While `fault`=1, every subsequent edge loads `if_id_valid`=0. `br_taken` is ignored.
- Not defined:
  - `fault` is tied to 0 and no checks are performed.
  - Out-of-range or misaligned fetches pass `imem_instr` through unchanged, including X, with `if_id_valid`=1.

## Test plan
- Reset release, no stall/branch, memory words W0..W3 at 0..12: after edges 1-4, `if_id_pc`=0,4,8,12 with matching `if_id_instr`, `if_id_valid`=1; `imem_addr`=16 after edge 4.
- `stall`=1 for 3 cycles while `pc`=8: `imem_addr` stays 8 and IF/ID holds {4, W1, 1}. Release: next edge gives {8, W2, 1}.
- `br_taken`=1, `br_target`=0x40 with `stall`=1 at `pc`=12: after the edge, `if_id_valid`=0 and `imem_addr`=0x40. Next edge (no stall) gives {0x40, W16, 1}.
- Async `reset` pulse mid-cycle while `pc`=0x20: outputs go to reset values immediately, before any clock edge. First fetch after release is at RESET_PC.
- With `FETCH_FAULT_CHECK_EN`, `br_target`=0x3FE, then `br_target`=0x400 (IMEM_SIZE=1024): `fault`=1 after the first fetch at the bad address, `if_id_valid` stays 0, `pc` frozen, and a later `br_taken`=1 to 0 does not clear it. Only `reset` clears it.
- Without the macro, same stimulus: `fault` stays 0 and the fetch at 0x400 produces `if_id_valid`=1.
